wbs_ctrl: RTL and testbench

WBS_CTRL -- requirements
Module: wbs_ctrl

---
 rtl/fsic_wb_pkg.sv | 31 +++
 rtl/wbs_to_cnt.sv | 28 ++
 rtl/wbs_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_wbs_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsic_wb_pkg.sv
// Shared definitions for the MGMT Wishbone slave controller: FSM states,
// target indices and the error/timeout read pattern.
package fsic_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } wbs_state_e;

  typedef enum logic [2:0] {
    TGT_0     = 3'd0,
    TGT_1     = 3'd1,
    TGT_2     = 3'd2,
    TGT_LOCAL = 3'd3,
    TGT_ERR   = 3'd4
  } tgt_idx_e;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  function automatic tgt_idx_e decode_page(input logic [3:0] page);
    case (page)
      4'd0:    return TGT_0;
      4'd1:    return TGT_1;
      4'd2:    return TGT_2;
      4'd3:    return TGT_LOCAL;
      default: return TGT_ERR;
    endcase
  endfunction

endpackage

// File: rtl/wbs_to_cnt.sv
// Target response timer: starts at 1 on load, counts while enabled and
// flags expiry when the count reaches TIMEOUT.
module wbs_to_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load)
      cnt_q <= 16'd1;
    else if (en && (cnt_q != LIMIT))
      cnt_q <= cnt_q + 16'd1;
  end

  assign expire = en && (cnt_q == LIMIT);

endmodule

// File: rtl/wbs_ctrl.sv
// MGMT Wishbone classic slave: forwards window pages 0-2 to three targets
// with a response timeout, serves local status registers on page 3.
module wbs_ctrl
  import fsic_wb_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h3000_0000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] wbs_adr,
  input  logic [31:0] wbs_wdata,
  input  logic [3:0]  wbs_sel,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  output logic        wbs_ack,
  output logic [31:0] wbs_rdata,
  output logic [2:0]  tgt_req,
  output logic        tgt_we,
  output logic [11:0] tgt_adr,
  output logic [31:0] tgt_wdata,
  output logic [3:0]  tgt_sel,
  input  logic [2:0]  tgt_ack,
  input  logic [95:0] tgt_rdata,
  output logic        to_irq
);

  wbs_state_e  state_q, state_d;
  tgt_idx_e    tgt_q;
  logic [31:0] adr_q, wdata_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        ack_q, ack_d, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [31:0] last_to_adr_q, last_to_adr_d;
  logic        claim, latch, cnt_load, cnt_en, expire, sel_ack;
  logic [31:0] sel_rdata, local_rdata;

  // No claim while the previous ack is on the bus: stb is still high then.
  assign claim = wbs_cyc & wbs_stb & (wbs_adr[31:16] == BASE[31:16]) & ~ack_q;

  wbs_to_cnt #(.TIMEOUT(TIMEOUT)) u_to_cnt (
    .clk    (wb_clk),
    .rst_n  (wb_rst_n),
    .load   (cnt_load),
    .en     (cnt_en),
    .expire (expire)
  );

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    case (tgt_q)
      TGT_0:   begin sel_ack = tgt_ack[0]; sel_rdata = tgt_rdata[31:0];  end
      TGT_1:   begin sel_ack = tgt_ack[1]; sel_rdata = tgt_rdata[63:32]; end
      TGT_2:   begin sel_ack = tgt_ack[2]; sel_rdata = tgt_rdata[95:64]; end
      default: ;
    endcase
  end

  always_comb begin
    case (adr_q[11:0])
      12'h000: local_rdata = {to_cnt_q, 14'b0, state_q};
      12'h004: local_rdata = last_to_adr_q;
      default: local_rdata = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ack_d         = 1'b0;
    rdata_d       = '0;
    irq_d         = 1'b0;
    to_cnt_d      = to_cnt_q;
    last_to_adr_d = last_to_adr_q;
    latch         = 1'b0;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (claim) begin
          latch = 1'b1;
          if (decode_page(wbs_adr[15:12]) inside {TGT_0, TGT_1, TGT_2}) begin
            state_d  = ST_REQ;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_REQ: begin
        cnt_en = 1'b1;
        if (!wbs_cyc) begin
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          ack_d   = 1'b1;
          rdata_d = sel_rdata;
          state_d = ST_ACK;
        end else if (expire) begin
          ack_d         = 1'b1;
          rdata_d       = DEAD_BEEF;
          irq_d         = 1'b1;
          to_cnt_d      = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;
          last_to_adr_d = adr_q;
          state_d       = ST_ACK;
        end
      end
      ST_ACK: begin
        // Target/timeout responses already drove ack on entry; local and
        // error accesses produce theirs here, giving the two-cycle latency.
        state_d = ST_IDLE;
        if (!ack_q) begin
          ack_d = 1'b1;
          if (tgt_q == TGT_LOCAL) begin
            rdata_d = local_rdata;
            if (we_q && (adr_q[11:0] == 12'h000))
              to_cnt_d = '0;
          end else begin
            rdata_d = DEAD_BEEF;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q       <= ST_IDLE;
      ack_q         <= 1'b0;
      rdata_q       <= '0;
      irq_q         <= 1'b0;
      to_cnt_q      <= '0;
      last_to_adr_q <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_d;
      to_cnt_q      <= to_cnt_d;
      last_to_adr_q <= last_to_adr_d;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tgt_q   <= TGT_ERR;
      adr_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else if (latch) begin
      tgt_q   <= decode_page(wbs_adr[15:12]);
      adr_q   <= wbs_adr;
      wdata_q <= wbs_wdata;
      sel_q   <= wbs_sel;
      we_q    <= wbs_we;
    end
  end

  always_comb begin
    tgt_req = '0;
    if (state_q == ST_REQ) begin
      case (tgt_q)
        TGT_0:   tgt_req = 3'b001;
        TGT_1:   tgt_req = 3'b010;
        TGT_2:   tgt_req = 3'b100;
        default: tgt_req = '0;
      endcase
    end
  end

  assign wbs_ack   = ack_q;
  assign wbs_rdata = rdata_q;
  assign to_irq    = irq_q;
  assign tgt_we    = we_q;
  assign tgt_adr   = adr_q[11:0];
  assign tgt_wdata = wdata_q;
  assign tgt_sel   = sel_q;

endmodule

// File: tb/tb_wbs_ctrl.sv
// Randomized bench for wbs_ctrl against a transaction-level model of the
// window decode, target/timeout responses and local status registers.
module tb_wbs_ctrl;

  localparam int unsigned TO = 8;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [31:0] wbs_adr = '0, wbs_wdata = '0;
  logic [3:0]  wbs_sel = '0;
  logic        wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
  logic        wbs_ack;
  logic [31:0] wbs_rdata;
  logic [2:0]  tgt_req;
  logic        tgt_we;
  logic [11:0] tgt_adr;
  logic [31:0] tgt_wdata;
  logic [3:0]  tgt_sel;
  logic [2:0]  tgt_ack = '0;
  logic [95:0] tgt_rdata = '0;
  logic        to_irq;

  always #5 wb_clk = ~wb_clk;

  wbs_ctrl #(.BASE(32'h3000_0000), .TIMEOUT(TO)) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .wbs_adr   (wbs_adr),
    .wbs_wdata (wbs_wdata),
    .wbs_sel   (wbs_sel),
    .wbs_cyc   (wbs_cyc),
    .wbs_stb   (wbs_stb),
    .wbs_we    (wbs_we),
    .wbs_ack   (wbs_ack),
    .wbs_rdata (wbs_rdata),
    .tgt_req   (tgt_req),
    .tgt_we    (tgt_we),
    .tgt_adr   (tgt_adr),
    .tgt_wdata (tgt_wdata),
    .tgt_sel   (tgt_sel),
    .tgt_ack   (tgt_ack),
    .tgt_rdata (tgt_rdata),
    .to_irq    (to_irq)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [15:0] m_to_cnt = '0;
  logic [31:0] m_last   = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected response for a local or error-page read under the current model.
  function automatic logic [31:0] exp_read(input logic [31:0] adr);
    if (adr[15:12] != 4'd3) return 32'hDEAD_BEEF;
    case (adr[11:0])
      12'h000: return {m_to_cnt, 14'b0, 2'b10};
      12'h004: return m_last;
      default: return 32'h0;
    endcase
  endfunction

  // One master transfer; dly = target req cycle in which the target acks
  // (0 or > TO means never); drop_at = req cycle after which cyc falls.
  task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                        input logic [3:0] sel, input int dly, input int drop_at);
    logic [31:0] d [3];
    logic [3:0]  page;
    logic        hit, is_tgt, is_loc, chk_rd;
    logic [2:0]  own;
    int          exp_ack_n, exp_ack_at, exp_req_n, exp_irq;
    logic [31:0] exp_rd;
    int          ack_n = 0, ack_at = -1, req_n = 0, irq_n = 0, bad_idle = 0, unstable = 0;
    logic [31:0] rd_seen = '0, wd_seen = '0;
    logic [2:0]  req_seen = '0;
    logic [11:0] adr_seen = '0;
    logic [3:0]  sel_seen = '0;
    logic        we_seen = 1'b0;

    for (int i = 0; i < 3; i++) d[i] = $urandom;
    page   = adr[15:12];
    hit    = (adr[31:16] == 16'h3000);
    is_tgt = hit && (page < 4'd3);
    is_loc = hit && (page == 4'd3);
    own    = is_tgt ? (3'b001 << page[1:0]) : 3'b000;
    exp_ack_n = 1; exp_ack_at = 2; exp_req_n = 0; exp_irq = 0; exp_rd = '0; chk_rd = 1'b1;
    if (!hit) begin
      exp_ack_n = 0;
    end else if (is_tgt) begin
      if (drop_at > 0) begin
        exp_ack_n = 0; exp_req_n = drop_at;
      end else if (dly >= 1 && dly <= int'(TO)) begin
        exp_ack_at = dly + 1; exp_req_n = dly; exp_rd = d[page[1:0]];
      end else begin
        exp_ack_at = TO + 1; exp_req_n = TO; exp_rd = 32'hDEAD_BEEF; exp_irq = 1;
        if (m_to_cnt != 16'hFFFF) m_to_cnt = m_to_cnt + 16'd1;
        m_last = adr;
      end
    end else begin
      exp_rd = exp_read(adr);
      if (is_loc) begin
        chk_rd = !we;
        if (we && adr[11:0] == 12'h000) m_to_cnt = '0;
      end
    end

    @(negedge wb_clk);
    tgt_rdata = {d[2], d[1], d[0]};
    tgt_ack = '0;
    wbs_adr = adr; wbs_we = we; wbs_wdata = wd; wbs_sel = sel;
    wbs_cyc = 1'b1; wbs_stb = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge wb_clk);
      if (wbs_ack) begin
        ack_n++;
        if (ack_at < 0) ack_at = n;
        rd_seen = wbs_rdata;
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
      end else if (wbs_rdata != 32'h0) begin
        bad_idle++;
      end
      if (to_irq) irq_n++;
      if (tgt_req != 3'b000) begin
        req_n++;
        if (req_n == 1) begin
          req_seen = tgt_req; adr_seen = tgt_adr; wd_seen = tgt_wdata;
          sel_seen = tgt_sel; we_seen = tgt_we;
        end else if (tgt_req != req_seen || tgt_adr != adr_seen || tgt_wdata != wd_seen) begin
          unstable++;
        end
      end
      if (drop_at > 0 && n == drop_at) begin
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
      end
      tgt_ack = 3'($urandom_range(0, 7)) & ~own;
      if (is_tgt && tgt_req != 3'b000 && req_n == dly) tgt_ack = tgt_ack | own;
    end
    wbs_cyc = 1'b0; wbs_stb = 1'b0; tgt_ack = '0;

    check_eq("ack_count", 32'(ack_n), 32'(exp_ack_n));
    if (exp_ack_n == 1) begin
      check_eq("ack_latency", 32'(ack_at), 32'(exp_ack_at));
      if (chk_rd) check_eq("rdata", rd_seen, exp_rd);
    end
    check_eq("req_cycles", 32'(req_n), 32'(exp_req_n));
    check_eq("irq_pulses", 32'(irq_n), 32'(exp_irq));
    check_eq("rdata_idle_zero", 32'(bad_idle), 32'h0);
    if (exp_req_n > 0) begin
      check_eq("req_onehot", 32'(req_seen), 32'(own));
      check_eq("req_stable", 32'(unstable), 32'h0);
      check_eq("tgt_adr", 32'(adr_seen), 32'(adr[11:0]));
      check_eq("tgt_we", 32'(we_seen), 32'(we));
      check_eq("tgt_wdata", wd_seen, wd);
      check_eq("tgt_sel", 32'(sel_seen), 32'(sel));
    end
  endtask

  // Two reads with stb held high across the first acknowledge.
  task automatic b2b(input logic [31:0] a1, input logic [31:0] a2);
    logic [31:0] e1, e2;
    int ack_n = 0;
    e1 = exp_read(a1);
    e2 = exp_read(a2);
    @(negedge wb_clk);
    wbs_adr = a1; wbs_we = 1'b0; wbs_cyc = 1'b1; wbs_stb = 1'b1; tgt_ack = '0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge wb_clk);
      if (wbs_ack) begin
        ack_n++;
        if (ack_n == 1) begin
          check_eq("b2b_lat1", 32'(n), 32'd2);
          check_eq("b2b_rdata1", wbs_rdata, e1);
          wbs_adr = a2;
        end else begin
          check_eq("b2b_lat2", 32'(n), 32'd5);
          check_eq("b2b_rdata2", wbs_rdata, e2);
          wbs_cyc = 1'b0; wbs_stb = 1'b0;
        end
      end
    end
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    check_eq("b2b_acks", 32'(ack_n), 32'd2);
  endtask

  task automatic reset_mid_req();
    int ack_n = 0, irq_n = 0;
    @(negedge wb_clk);
    wbs_adr = 32'h3000_2040; wbs_we = 1'b0; wbs_cyc = 1'b1; wbs_stb = 1'b1; tgt_ack = '0;
    repeat (3) @(negedge wb_clk);
    check_eq("pre_rst_req", 32'(tgt_req), 32'h4);
    #2 wb_rst_n = 1'b0;
    #1;
    check_eq("rst_req_drop", 32'(tgt_req), 32'h0);
    check_eq("rst_ack", 32'(wbs_ack), 32'h0);
    check_eq("rst_irq", 32'(to_irq), 32'h0);
    @(negedge wb_clk);
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    m_to_cnt = '0;
    m_last   = '0;
    for (int n = 0; n < 12; n++) begin
      @(negedge wb_clk);
      if (wbs_ack) ack_n++;
      if (to_irq) irq_n++;
    end
    check_eq("post_rst_ack", 32'(ack_n), 32'h0);
    check_eq("post_rst_irq", 32'(irq_n), 32'h0);
  endtask

  initial begin
    logic [15:0] hi;
    logic [3:0]  page;
    logic [11:0] off;

    repeat (3) @(negedge wb_clk);
    check_eq("reset_ack", 32'(wbs_ack), 32'h0);
    check_eq("reset_req", 32'(tgt_req), 32'h0);
    check_eq("reset_irq", 32'(to_irq), 32'h0);
    check_eq("reset_rdata", wbs_rdata, 32'h0);
    wb_rst_n = 1'b1;

    access(32'h3000_3000, 1'b0, '0, 4'hF, 0, 0);
    access(32'h3000_3004, 1'b0, '0, 4'hF, 0, 0);
    access(32'h3000_1010, 1'b0, '0, 4'hF, 4, 0);
    access(32'h3000_0000, 1'b1, 32'hCAFE_F00D, 4'h3, 0, 0);
    access(32'h3000_3000, 1'b0, '0, 4'hF, 0, 0);
    access(32'h3000_3004, 1'b0, '0, 4'hF, 0, 0);
    access(32'h3000_2100, 1'b0, '0, 4'hF, 8, 0);
    access(32'h3000_3000, 1'b0, '0, 4'hF, 0, 0);
    access(32'h3000_3008, 1'b1, 32'h1111_2222, 4'hF, 0, 0);
    access(32'h3000_3004, 1'b1, 32'h0, 4'hF, 0, 0);
    access(32'h3000_3004, 1'b0, '0, 4'hF, 0, 0);
    access(32'h3000_5000, 1'b0, '0, 4'hF, 0, 0);
    access(32'h3100_0000, 1'b0, '0, 4'hF, 0, 0);
    access(32'h3000_0ABC, 1'b1, 32'h5555_AAAA, 4'hC, 0, 3);
    reset_mid_req();
    access(32'h3000_0044, 1'b0, '0, 4'hF, 2, 0);
    access(32'h3000_3000, 1'b0, '0, 4'hF, 0, 0);
    b2b(32'h3000_3000, 32'h3000_6000);
    b2b(32'h3000_3004, 32'h3000_3004);
    access(32'h3000_3000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 0);
    access(32'h3000_3000, 1'b0, '0, 4'hF, 0, 0);

    for (int t = 0; t < 40; t++) begin
      hi   = ($urandom_range(0, 9) == 0) ? 16'h3100 : 16'h3000;
      page = 4'($urandom_range(0, 7));
      if (page == 4'd3) begin
        case ($urandom_range(0, 3))
          0:       off = 12'h000;
          1:       off = 12'h004;
          2:       off = 12'h008;
          default: off = 12'($urandom) & 12'hFFC;
        endcase
      end else begin
        off = 12'($urandom);
      end
      access({hi, page, off}, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
             int'($urandom_range(0, 10)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
